ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-port synchronous RAM between two independent requesters. Each cycle it grants at most one request, drives the RAM's `data`/`addr`/`we` inputs from the granted requester, and routes the RAM's read data back with a per-requester valid pulse one cycle later. It sits directly in front of a `ram` instance, so two clients (for example a loader and a consumer) can use one memory without external muxing.

---
 rtl/ram_arbiter.sv | 95 +++++++++
 tb/tb_ram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-requester round-robin front end for one single-port synchronous RAM.
// At most one request is granted per cycle. The granted requester drives the
// RAM directly. A granted read returns ram_q one cycle later with a
// per-requester valid pulse.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req0/1, we0/1           request and write-enable per requester
//   addr0/1, wdata0/1       access address and write data per requester
//   gnt0/1                  combinational grant
//   rvld0/1                 registered read-data-valid per requester
//   rdata                   shared read data (pass-through of ram_q)
//   ram_data/addr/we        drive to the RAM
//   ram_q                   read data from the RAM
module ram_arbiter #(
   parameter int DATA_WIDTH = 3,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvld0,
   output logic                  rvld1,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   logic                  r_last;
   logic [1:0]            r_rd_pend;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic                  w_gnt0;
   logic                  w_gnt1;

   // On a tie the requester that was not granted last wins. r_last resets to
   // 1 so requester 0 takes the first tie.
   assign w_gnt0 = rst_n & req0 & (~req1 | r_last);
   assign w_gnt1 = rst_n & req1 & (~req0 | ~r_last);

   assign gnt0 = w_gnt0;
   assign gnt1 = w_gnt1;

   always_comb begin
      ram_we   = 1'b0;
      ram_data = '0;
      ram_addr = rst_n ? r_addr : '0;
      if (w_gnt0) begin
         ram_we   = we0;
         ram_data = wdata0;
         ram_addr = addr0;
      end else if (w_gnt1) begin
         ram_we   = we1;
         ram_data = wdata1;
         ram_addr = addr1;
      end
   end

   // r_addr keeps the last granted address on the RAM during idle cycles so
   // ram_q does not move.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last    <= 1'b1;
         r_rd_pend <= 2'b00;
         r_addr    <= '0;
      end else if (w_gnt0) begin
         r_last    <= 1'b0;
         r_rd_pend <= we0 ? 2'b00 : 2'b01;
         r_addr    <= addr0;
      end else if (w_gnt1) begin
         r_last    <= 1'b1;
         r_rd_pend <= we1 ? 2'b00 : 2'b10;
         r_addr    <= addr1;
      end else begin
         r_rd_pend <= 2'b00;
      end
   end

   assign rvld0 = r_rd_pend[0];
   assign rvld1 = r_rd_pend[1];
   assign rdata = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter with a behavioral single-port synchronous RAM
// (registered address, write-first) attached to the arbiter's RAM port.
module tb_ram_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [2:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, rvld0, rvld1;
   logic [2:0] rdata, ram_data, ram_addr, ram_q;
   logic       ram_we;

   ram_arbiter #(.DATA_WIDTH(3), .ADDR_WIDTH(3)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .rvld0    (rvld0),
      .rvld1    (rvld1),
      .rdata    (rdata),
      .ram_data (ram_data),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_q    (ram_q)
   );

   // RAM: address registered at the edge, so a word written at an edge is
   // visible on q right after it.
   logic [2:0] mem [8];
   logic [2:0] ram_areg;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      ram_areg <= ram_addr;
   end
   assign ram_q = mem[ram_areg];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Reference model
   logic [2:0] ref_mem [8];
   logic       m_last;
   logic [1:0] m_pend;
   logic [2:0] m_addr;
   logic [2:0] m_qaddr;
   bit         q_ok;
   logic [3:0] sb_q [$];   // {requester, data}
   bit         seen_g0, seen_g1;

   task automatic cycle(input bit rst_in, input bit rst_late,
                        input bit r0, input bit w0, input logic [2:0] a0, input logic [2:0] d0,
                        input bit r1, input bit w1, input logic [2:0] a1, input logic [2:0] d1);
      bit eg0, eg1, ewe;
      logic [2:0] eaddr, edata;
      logic [3:0] ent;
      @(negedge clk);
      rst_n = rst_in;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      eg0 = rst_in && r0 && (!r1 || m_last);
      eg1 = rst_in && r1 && (!r0 || !m_last);
      if (eg0) begin
         ewe = w0; eaddr = a0; edata = d0;
      end else if (eg1) begin
         ewe = w1; eaddr = a1; edata = d1;
      end else begin
         ewe = 1'b0; edata = 3'd0; eaddr = rst_in ? m_addr : 3'd0;
      end
      check("gnt0", gnt0, eg0);
      check("gnt1", gnt1, eg1);
      check("ram_we", ram_we, ewe);
      check("ram_addr", ram_addr, eaddr);
      check("ram_data", ram_data, edata);
      check("rvld0", rvld0, m_pend[0]);
      check("rvld1", rvld1, m_pend[1]);
      if (q_ok) check("rdata_q", rdata, ref_mem[m_qaddr]);
      if (m_pend != 2'b00) begin
         check("sb_size", sb_q.size(), 1);
         if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            check("rd_owner", {31'd0, ent[3]}, {31'd0, m_pend[1]});
            check("rd_data", rdata, ent[2:0]);
         end
      end
      seen_g0 = gnt0;
      seen_g1 = gnt1;
      if (rst_late) begin
         #3 rst_n = 1'b0;
      end
      @(posedge clk);
      m_qaddr = rst_late ? 3'd0 : eaddr;
      if (!rst_in || rst_late) begin
         m_last = 1'b1;
         m_pend = 2'b00;
         m_addr = 3'd0;
         sb_q.delete();
      end else if (eg0) begin
         m_last = 1'b0;
         m_addr = a0;
         if (w0) begin
            ref_mem[a0] = d0;
            m_pend = 2'b00;
         end else begin
            sb_q.push_back({1'b0, ref_mem[a0]});
            m_pend = 2'b01;
         end
      end else if (eg1) begin
         m_last = 1'b1;
         m_addr = a1;
         if (w1) begin
            ref_mem[a1] = d1;
            m_pend = 2'b00;
         end else begin
            sb_q.push_back({1'b1, ref_mem[a1]});
            m_pend = 2'b10;
         end
      end else begin
         m_pend = 2'b00;
      end
   endtask

   task automatic idle();
      cycle(1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 3'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 3'd0;
      m_last = 1'b1; m_pend = 2'b00; m_addr = 3'd0; m_qaddr = 3'd0; q_ok = 0;

      // Reset
      cycle(0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 3'd0);
      cycle(0, 0, 1, 1, 3'd2, 3'd7, 1, 1, 3'd4, 3'd6);  // requests ignored in reset
      // Initialise RAM through the arbiter
      for (int i = 0; i < 8; i++) cycle(1, 0, 1, 1, i[2:0], 3'd0, 0, 0, 3'd0, 3'd0);
      q_ok = 1;

      // 1: write then read back on requester 0
      cycle(0, 0, 0, 0, 3'd0, 3'd0, 0, 0, 3'd0, 3'd0);
      cycle(1, 0, 1, 1, 3'd3, 3'd5, 0, 0, 3'd0, 3'd0);
      check("t1_gnt0_wr", {31'd0, seen_g0}, 1);
      cycle(1, 0, 1, 0, 3'd3, 3'd0, 0, 0, 3'd0, 3'd0);
      check("t1_gnt0_rd", {31'd0, seen_g0}, 1);
      idle();

      // 2: continuous contention, alternating grants
      cycle(1, 0, 1, 1, 3'd1, 3'd4, 0, 0, 3'd0, 3'd0);
      cycle(1, 0, 0, 0, 3'd0, 3'd0, 1, 1, 3'd2, 3'd6);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 0, 1, 0, 3'd1, 3'd0, 1, 0, 3'd2, 3'd0);
         check("t2_order", {31'd0, seen_g1}, (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      idle();

      // 3: write then read same address from the other requester
      cycle(1, 0, 1, 1, 3'd7, 3'd2, 0, 0, 3'd0, 3'd0);
      cycle(1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 3'd7, 3'd0);
      idle();

      // 4: read followed by an idle gap
      cycle(1, 0, 1, 1, 3'd5, 3'd3, 0, 0, 3'd0, 3'd0);
      cycle(1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 3'd5, 3'd0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("t4_hold_addr", ram_addr, 3'd5);
         check("t4_rdata", rdata, 3'd3);
      end

      // 5: reset lands on the edge ending a read grant
      cycle(1, 0, 1, 1, 3'd4, 3'd1, 0, 0, 3'd0, 3'd0);
      cycle(1, 1, 0, 0, 3'd0, 3'd0, 1, 0, 3'd4, 3'd0);
      check("t5_gnt1", {31'd0, seen_g1}, 1);
      cycle(0, 0, 1, 0, 3'd1, 3'd0, 1, 0, 3'd4, 3'd0);
      cycle(1, 0, 1, 0, 3'd1, 3'd0, 1, 0, 3'd4, 3'd0);
      check("t5_first_tie", {31'd0, seen_g0}, 1);
      idle();

      // 6: withdrawn request from requester 1
      cycle(1, 0, 0, 0, 3'd0, 3'd0, 1, 1, 3'd6, 3'd5);
      cycle(1, 0, 1, 1, 3'd0, 3'd4, 1, 1, 3'd2, 3'd7);
      check("t6_no_gnt1", {31'd0, seen_g1}, 0);
      idle();
      cycle(1, 0, 0, 0, 3'd0, 3'd0, 1, 0, 3'd2, 3'd0);
      idle();
      check("t6_mem2", rdata, 3'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
